// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared constants and FSM state type for the digit-serial BCD adder.
// Imported by the adder, the bus interface and the controller.
package bcd_serial_add_ctrl_pkg;

    localparam int         BCD_DIGIT_W   = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Start/result bundle of the serial BCD adder.
// master drives a request, slave is the sequencer.
interface bcd_serial_add_ctrl_if
    import bcd_serial_add_ctrl_pkg::*;
#(
    parameter int DIGITS = 4
);

    logic                          start_i;
    logic [BCD_DIGIT_W*DIGITS-1:0] a_i;
    logic [BCD_DIGIT_W*DIGITS-1:0] b_i;
    logic                          carry_i;
    logic                          ready_o;
    logic                          done_o;
    logic [BCD_DIGIT_W*DIGITS-1:0] sum_o;
    logic                          carry_o;
    logic                          err_o;

    modport master (
        output start_i, a_i, b_i, carry_i,
        input  ready_o, done_o, sum_o, carry_o, err_o
    );

    modport slave (
        input  start_i, a_i, b_i, carry_i,
        output ready_o, done_o, sum_o, carry_o, err_o
    );

endinterface

// File: rtl/bcd_adder.sv
// Single-digit combinational BCD adder with carry in/out.
// Digits >9 still give a deterministic (meaningless) result.
module bcd_adder
    import bcd_serial_add_ctrl_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a_i,
    input  logic [BCD_DIGIT_W-1:0] b_i,
    output logic [BCD_DIGIT_W-1:0] sum_o,
    input  logic                   carry_i,
    output logic                   carry_o
);

    logic [BCD_DIGIT_W:0] raw;

    // Binary add, then +6 correction when the digit overflows 9.
    always_comb begin
        raw     = {1'b0, a_i} + {1'b0, b_i} + {4'd0, carry_i};
        sum_o   = raw[3:0];
        carry_o = 1'b0;
        if (raw > {1'b0, BCD_MAX_DIGIT}) begin
            sum_o   = raw[3:0] + 4'd6;
            carry_o = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial N-digit packed-BCD adder: one shared bcd_adder,
// LSD first, carry rippled through a register.
module bcd_serial_add_ctrl
    import bcd_serial_add_ctrl_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    bcd_serial_add_ctrl_if.slave  bus
);

    localparam int W     = BCD_DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     a_q, b_q, sum_q;
    logic             carry_q, carry_out_q;
    logic             err_flag_q, err_q;
    logic             accept, err_next;
    logic [3:0]       a_dig, b_dig, add_sum;
    logic             add_co;

    bcd_adder u_adder (
        .a_i     (a_dig),
        .b_i     (b_dig),
        .sum_o   (add_sum),
        .carry_i (carry_q),
        .carry_o (add_co)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        bus.ready_o = 1'b0;
        bus.done_o  = 1'b0;
        accept      = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.ready_o = 1'b1;
                accept      = bus.start_i;
                if (bus.start_i) state_d = RUN;
            end
            RUN: begin
                if (idx_q == LAST) state_d = DONE;
            end
            DONE: begin
                bus.ready_o = 1'b1;
                bus.done_o  = 1'b1;
                accept      = bus.start_i;
                state_d     = bus.start_i ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit select and invalid-digit scan of the incoming operands.
    always_comb begin
        a_dig    = '0;
        b_dig    = '0;
        err_next = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                a_dig = a_q[k*BCD_DIGIT_W +: BCD_DIGIT_W];
                b_dig = b_q[k*BCD_DIGIT_W +: BCD_DIGIT_W];
            end
            if (bus.a_i[k*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT ||
                bus.b_i[k*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT)
                err_next = 1'b1;
        end
    end

    // Operand latch on accept, one digit written per RUN cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            err_flag_q  <= 1'b0;
            err_q       <= 1'b0;
        end else if (accept) begin
            a_q        <= bus.a_i;
            b_q        <= bus.b_i;
            carry_q    <= bus.carry_i;
            err_flag_q <= err_next;
            sum_q      <= '0;
            idx_q      <= '0;
        end else if (state_q == RUN) begin
            for (int k = 0; k < DIGITS; k++)
                if (idx_q == IDX_W'(k))
                    sum_q[k*BCD_DIGIT_W +: BCD_DIGIT_W] <= add_sum;
            carry_q <= add_co;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == LAST) begin
                idx_q       <= '0;
                carry_out_q <= add_co;
                err_q       <= err_flag_q;
            end
        end
    end

    assign bus.sum_o   = sum_q;
    assign bus.carry_o = carry_out_q;
    assign bus.err_o   = err_q;

endmodule
